// File: rtl/conv1d_1st_data_loader.sv
// conv1d_1st_data_loader
//   Frame sequencer and sole RAM master for the first CONV1D layer.
//   Loads one frame of samples into the 5-tap data RAM, then sweeps the
//   read address 0..Frame_Len-1 so the conv engine gets one window per cycle.
//   Optional macro CONV1D_LOADER_SATURATE_EN: saturate samples to Bit_width
//   instead of truncating them.
module conv1d_1st_data_loader #(
   parameter int Bit_width = 16,
   parameter int RAM_Depth = 512,
   parameter int Frame_Len = 512,
   parameter int IN_WIDTH  = 24
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       start,
   input  logic                       in_valid,
   input  logic signed [IN_WIDTH-1:0] in_data,
   output logic                       in_ready,
   output logic                       Write_Enable,
   output logic [8:0]                 Write_Width,
   output logic [Bit_width-1:0]       data_in,
   output logic                       Read_Enable,
   output logic [8:0]                 Read_Width,
   input  logic                       hold,
   output logic                       window_valid,
   output logic [8:0]                 window_idx,
   output logic                       frame_done,
   output logic                       busy
);

   // A frame never exceeds the RAM; clamp so an oversized setting cannot wrap.
   localparam int FLEN = (Frame_Len > RAM_Depth) ? RAM_Depth : Frame_Len;
   localparam logic [8:0] LAST = 9'(FLEN - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SWEEP, DRAIN} state_t;

   state_t               state, state_n;
   logic [8:0]           wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic                 we_n, re_n;
   logic [8:0]           ww_n, rw_n;
   logic [Bit_width-1:0] din_n;

`ifdef CONV1D_LOADER_SATURATE_EN
   localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
      {{(IN_WIDTH-Bit_width+1){1'b0}}, {(Bit_width-1){1'b1}}};
   localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
      {{(IN_WIDTH-Bit_width+1){1'b1}}, {(Bit_width-1){1'b0}}};

   function automatic logic [Bit_width-1:0] conv(input logic signed [IN_WIDTH-1:0] d);
      if (d > SAT_MAX)      conv = {1'b0, {(Bit_width-1){1'b1}}};
      else if (d < SAT_MIN) conv = {1'b1, {(Bit_width-1){1'b0}}};
      else                  conv = d[Bit_width-1:0];
   endfunction
`else
   // Plain truncation: the upper sample bits are intentionally dropped.
   logic unused_in_hi;
   assign unused_in_hi = ^in_data[IN_WIDTH-1:Bit_width];

   function automatic logic [Bit_width-1:0] conv(input logic signed [IN_WIDTH-1:0] d);
      conv = d[Bit_width-1:0];
   endfunction
`endif

   // Next-state and next-output logic; strobes default low every cycle.
   always_comb begin
      state_n  = state;
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      we_n     = 1'b0;
      ww_n     = Write_Width;
      din_n    = data_in;
      re_n     = 1'b0;
      rw_n     = Read_Width;
      case (state)
         IDLE: begin
            if (start) begin
               state_n  = LOAD;
               wr_ptr_n = '0;
            end
         end
         LOAD: begin
            if (in_valid && in_ready) begin
               we_n     = 1'b1;
               ww_n     = wr_ptr;
               din_n    = conv(in_data);
               wr_ptr_n = wr_ptr + 9'd1;
               if (wr_ptr == LAST) state_n = SETTLE;
            end
         end
         SETTLE: begin
            // Final write commits on this cycle's negedge before any read.
            rd_ptr_n = '0;
            state_n  = SWEEP;
         end
         SWEEP: begin
            if (!hold) begin
               re_n     = 1'b1;
               rw_n     = rd_ptr;
               rd_ptr_n = rd_ptr + 9'd1;
               if (rd_ptr == LAST) state_n = DRAIN;
            end
         end
         DRAIN:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State and pointer registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state  <= state_n;
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
      end
   end

   // Registered outputs; window fields trail the read strobe by one cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         Write_Enable <= 1'b0;
         Write_Width  <= '0;
         data_in      <= '0;
         Read_Enable  <= 1'b0;
         Read_Width   <= '0;
         window_valid <= 1'b0;
         window_idx   <= '0;
         frame_done   <= 1'b0;
      end else begin
         in_ready     <= (state_n == LOAD);
         busy         <= (state_n != IDLE);
         Write_Enable <= we_n;
         Write_Width  <= ww_n;
         data_in      <= din_n;
         Read_Enable  <= re_n;
         Read_Width   <= rw_n;
         window_valid <= Read_Enable;
         window_idx   <= Read_Width;
         frame_done   <= Read_Enable && (Read_Width == LAST);
      end
   end

endmodule

// File: tb/tb_conv1d_1st_data_loader.sv
// Directed bench for conv1d_1st_data_loader (Frame_Len = 8) with write/read/window scoreboards.
module tb_conv1d_1st_data_loader;
   localparam int FL = 8;
   localparam int BW = 16;
   localparam int IW = 24;

   logic          CLK = 1'b0, RST = 1'b1, start = 1'b0, in_valid = 1'b0, hold = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic          in_ready, Write_Enable, Read_Enable, window_valid, frame_done, busy;
   logic [8:0]    Write_Width, Read_Width, window_idx;
   logic [BW-1:0] data_in;
   logic [48:0]   outs;

   conv1d_1st_data_loader #(.Bit_width(BW), .RAM_Depth(512), .Frame_Len(FL), .IN_WIDTH(IW)) dut (
      .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .Write_Enable(Write_Enable), .Write_Width(Write_Width),
      .data_in(data_in), .Read_Enable(Read_Enable), .Read_Width(Read_Width), .hold(hold),
      .window_valid(window_valid), .window_idx(window_idx), .frame_done(frame_done), .busy(busy));

   assign outs = {in_ready, Write_Enable, Write_Width, data_in, Read_Enable, Read_Width,
                  window_valid, window_idx, frame_done, busy};

   always #5 CLK = ~CLK;

   typedef struct packed {logic [8:0] a; logic [15:0] d;} wr_t;
   wr_t           wq[$];
   logic [8:0]    rq[$];
   logic [8:0]    vq[$];
   wr_t           we_exp;
   logic [8:0]    idx_exp;
   logic [IW-1:0] samples [FL];
   int errors = 0, checks = 0, frames = 0, cyc = 0, f0 = 0;
   int re_first = -1, re_last = -1;
   logic       prev_re = 1'b0;
   logic [8:0] prev_rw = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] bconv(input logic [23:0] d);
`ifdef CONV1D_LOADER_SATURATE_EN
      if ($signed(d) > 24'sd32767)  return 16'h7FFF;
      if ($signed(d) < -24'sd32768) return 16'h8000;
`endif
      return d[15:0];
   endfunction

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge CLK) begin
      cyc++;
      if (RST) begin
         prev_re = 1'b0;
      end else begin
         chk("we_re_exclusive", 64'(Write_Enable & Read_Enable), 0);
         if (Write_Enable) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               we_exp = wq.pop_front();
               chk("write_addr", 64'(Write_Width), 64'(we_exp.a));
               chk("write_data", 64'(data_in), 64'(we_exp.d));
            end
         end
         if (Read_Enable) begin
            if (re_first < 0) re_first = cyc;
            re_last = cyc;
            if (rq.size() == 0) chk("unexpected_read", 1, 0);
            else chk("read_addr", 64'(Read_Width), 64'(rq.pop_front()));
         end
         chk("window_valid_latency", 64'(window_valid), 64'(prev_re));
         if (window_valid) begin
            chk("window_idx_latency", 64'(window_idx), 64'(prev_rw));
            if (vq.size() == 0) chk("unexpected_window", 1, 0);
            else begin
               idx_exp = vq.pop_front();
               chk("window_idx", 64'(window_idx), 64'(idx_exp));
               chk("frame_done", 64'(frame_done), 64'(idx_exp == 9'(FL-1)));
            end
            if (frame_done) frames++;
         end else begin
            chk("frame_done_no_window", 64'(frame_done), 0);
         end
         prev_re = Read_Enable;
         prev_rw = Read_Width;
      end
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic send(input logic [IW-1:0] d, input int gap);
      bit acc;
      int n;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      do begin
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   // Load samples[0..cnt-1]; cnt == FL also queues the full sweep.
   task automatic load_frame(input int cnt, input int gap_odd, input logic hold_load);
      f0 = frames;
      re_first = -1;
      hold = hold_load;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("in_ready_after_start", 64'(in_ready), 1);
      chk("busy_after_start", 64'(busy), 1);
      for (int i = 0; i < cnt; i++) begin
         wq.push_back({9'(i), bconv(samples[i])});
         send(samples[i], (i % 2 == 1) ? gap_odd : 0);
      end
      if (cnt == FL) begin
         hold = 1'b0;
         chk("in_ready_drop", 64'(in_ready), 0);
         for (int i = 0; i < FL; i++) begin
            rq.push_back(9'(i));
            vq.push_back(9'(i));
         end
      end
   endtask

   task automatic finish_frame(input int holds);
      int n;
      n = 0;
      while (frames == f0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("frame_done_seen", 64'(frames), 64'(f0 + 1));
      chk("busy_at_done", 64'(busy), 0);
      chk("sweep_span", 64'(re_last - re_first), 64'(FL - 1 + holds));
      chk("queues_empty", 64'(wq.size() + rq.size() + vq.size()), 0);
      tick();
   endtask

   initial begin
      // 1. reset, then idle
      repeat (3) tick();
      chk("reset_outputs", 64'(outs), 0);
      RST = 1'b0;
      repeat (5) begin
         @(negedge CLK);
         chk("idle_outputs", 64'(outs), 0);
      end
      tick();

      // 2/3. back-to-back samples 1..8, free-running sweep
      for (int i = 0; i < FL; i++) samples[i] = IW'(i + 1);
      load_frame(FL, 0, 1'b0);
      finish_frame(0);

      // 4. gapped load with hold asserted during LOAD, then a 3-cycle stall at rd_ptr 3
      for (int i = 0; i < FL; i++) samples[i] = IW'(16'h0A00 + i);
      load_frame(FL, 1, 1'b1);
      begin
         int n;
         n = 0;
         while (!(Read_Enable && Read_Width == 9'd2) && n < 50) begin
            @(negedge CLK);
            n++;
         end
         chk("reached_idx2", 64'(Read_Enable && Read_Width == 9'd2), 1);
      end
      hold  = 1'b1;
      start = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("hold_read_low", 64'(Read_Enable), 0);
         chk("start_in_sweep_no_ready", 64'(in_ready), 0);
         chk("busy_in_sweep", 64'(busy), 1);
      end
      hold  = 1'b0;
      start = 1'b0;
      finish_frame(3);

      // 5. conversion extremes
      samples[0] = 24'h7FFFFF; samples[1] = 24'h800000; samples[2] = 24'h000005;
      samples[3] = 24'hFFFFFB; samples[4] = 24'h123456; samples[5] = 24'hFF8000;
      samples[6] = 24'h007FFF; samples[7] = 24'hFEDCBA;
      load_frame(FL, 0, 1'b0);
      finish_frame(0);

      // 6. reset after 4 accepts, then a clean reload from address 0
      for (int i = 0; i < FL; i++) samples[i] = IW'(24'h000100 + i);
      load_frame(4, 0, 1'b0);
      @(negedge CLK);
      #1 RST = 1'b1;
      #1 chk("outputs_in_reset", 64'(outs), 0);
      chk("aborted_writes_seen", 64'(wq.size()), 0);
      repeat (2) tick();
      chk("outputs_held_reset", 64'(outs), 0);
      RST = 1'b0;
      tick();
      chk("idle_after_reset", 64'(outs), 0);
      for (int i = 0; i < FL; i++) samples[i] = IW'(24'h000200 + 3 * i);
      load_frame(FL, 0, 1'b0);
      finish_frame(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
